// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
//   Shared definitions for the multi-cycle MIPS-subset main controller:
//   opcode constants, the controller state enum, ALU-op and PC-source
//   encodings, and the decoded opcode-class record passed between
//   opcode_class and multicycle_ctrl.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Supported primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    // One-hot instruction class; exactly one field is set for any opcode
    typedef struct packed {
        logic rtype;
        logic addi;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// ----------------------------------------------------------------------------
// opcode_class
//   Purely combinational opcode-to-class decoder.
//   Ports:
//     opcode    in  6   primary opcode field
//     op_class  out     one-hot class record (rtype/addi/load/store/
//                       branch/jump/illegal)
// ----------------------------------------------------------------------------
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_RTYPE: op_class.rtype   = 1'b1;
            OP_ADDI:  op_class.addi    = 1'b1;
            OP_LW:    op_class.load    = 1'b1;
            OP_SW:    op_class.store   = 1'b1;
            OP_BEQ:   op_class.branch  = 1'b1;
            OP_J:     op_class.jump    = 1'b1;
            default:  op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle main controller for the MIPS-subset CPU. Sequences
//   FETCH/DECODE/EXEC/MEM/WB for R-type, addi, lw, sw, beq and j, drives all
//   datapath selects and write strobes, handshakes with the instruction and
//   data memories and counts retired instructions.
//   Ports:
//     clk_i, rst_i (async, active-low)
//     start_i        run enable, sampled in IDLE and at retirement
//     opcode_i       IR opcode field, valid from DECODE onward
//     zero_i         ALU zero flag, valid in EXEC
//     imem_ready_i   instruction memory data valid
//     dmem_ready_i   data memory access completes
//     imem_req_o, ir_write_o, pc_write_o, pc_src_o[1:0], reg_dst_o,
//     alu_src_o, alu_op_o[1:0], mem_read_o, mem_write_o, mem_to_reg_o,
//     reg_write_o, illegal_o, busy_o   control outputs
//     instr_cnt_o[CNT_W-1:0]           retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             illegal_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    state_t           state_next;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_reg;
    logic             retire;
    logic [5:0]       class_opcode;
    op_class_t        cls;

    // During DECODE the opcode is not latched yet, so j and illegal must be
    // decoded straight from the IR; every later state uses the latched copy.
    assign class_opcode = (state_reg == ST_DECODE) ? opcode_i : op_q;

    opcode_class u_opcode_class (
        .opcode   (class_opcode),
        .op_class (cls)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            op_q      <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                op_q <= opcode_i;
            end
            if (retire) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        retire       = 1'b0;
        imem_req_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = PC_SRC_SEQ;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        alu_op_o     = ALU_OP_ADD;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        illegal_o    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req_o = 1'b1;
                // IR load and PC+4 update happen in the same cycle the
                // instruction memory returns data.
                if (imem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    pc_src_o   = PC_SRC_SEQ;
                    state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                reg_dst_o = cls.rtype;
                if (cls.jump) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = PC_SRC_JUMP;
                    retire     = 1'b1;
                end else if (cls.illegal) begin
                    illegal_o = 1'b1;
                    retire    = 1'b1;
                end else begin
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                reg_dst_o = cls.rtype;
                if (cls.rtype) begin
                    alu_op_o   = ALU_OP_FUNCT;
                    state_next = ST_WB;
                end else if (cls.addi) begin
                    alu_src_o  = 1'b1;
                    state_next = ST_WB;
                end else if (cls.load || cls.store) begin
                    alu_src_o  = 1'b1;
                    state_next = ST_MEM;
                end else if (cls.branch) begin
                    alu_op_o   = ALU_OP_SUB;
                    pc_src_o   = PC_SRC_BRANCH;
                    pc_write_o = zero_i;
                    retire     = 1'b1;
                end else begin
                    // Unreachable: j/illegal never leave DECODE for EXEC.
                    state_next = ST_IDLE;
                end
            end

            ST_MEM: begin
                // Address computation stays selected while the data memory
                // stalls so the address bus is stable for the whole access.
                alu_src_o   = 1'b1;
                mem_read_o  = cls.load;
                mem_write_o = cls.store;
                if (dmem_ready_i) begin
                    if (cls.load) begin
                        state_next = ST_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end

            ST_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = cls.rtype;
                mem_to_reg_o = cls.load;
                retire       = 1'b1;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Instruction boundary: start_i decides whether to keep running.
        if (retire) begin
            state_next = start_i ? ST_FETCH : ST_IDLE;
        end
    end

    assign busy_o      = (state_reg != ST_IDLE);
    assign instr_cnt_o = cnt_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [5:0]  opcode_i;
    logic        zero_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic        imem_req_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic [1:0]  pc_src_o;
    logic        reg_dst_o;
    logic        alu_src_o;
    logic [1:0]  alu_op_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        mem_to_reg_o;
    logic        reg_write_o;
    logic        illegal_o;
    logic        busy_o;
    logic [31:0] instr_cnt_o;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .opcode_i     (opcode_i),
        .zero_i       (zero_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .imem_req_o   (imem_req_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .reg_dst_o    (reg_dst_o),
        .alu_src_o    (alu_src_o),
        .alu_op_o     (alu_op_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .illegal_o    (illegal_o),
        .busy_o       (busy_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Packed view of all single-bit/select outputs for table comparison
    logic [14:0] outs;
    assign outs = {imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_dst_o,
                   alu_src_o, alu_op_o, mem_read_o, mem_write_o, mem_to_reg_o,
                   reg_write_o, illegal_o, busy_o};

    localparam logic [14:0] IMEM   = 15'h4000;
    localparam logic [14:0] IRW    = 15'h2000;
    localparam logic [14:0] PCW    = 15'h1000;
    localparam logic [14:0] PCS_J  = 15'h0800;
    localparam logic [14:0] PCS_BR = 15'h0400;
    localparam logic [14:0] RDST   = 15'h0200;
    localparam logic [14:0] ASRC   = 15'h0100;
    localparam logic [14:0] AOP_FN = 15'h0080;
    localparam logic [14:0] AOP_SB = 15'h0040;
    localparam logic [14:0] MRD    = 15'h0020;
    localparam logic [14:0] MWR    = 15'h0010;
    localparam logic [14:0] M2R    = 15'h0008;
    localparam logic [14:0] RW     = 15'h0004;
    localparam logic [14:0] ILL    = 15'h0002;
    localparam logic [14:0] BUSY   = 15'h0001;
    localparam logic [14:0] NONE   = 15'h0000;
    localparam logic [14:0] F_RDY  = IMEM | IRW | PCW | BUSY;
    localparam logic [14:0] F_WAIT = IMEM | BUSY;

    typedef struct packed {
        logic        start;
        logic [5:0]  op;
        logic        iready;
        logic        dready;
        logic        zero;
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [5:0] op,
                                input logic ir, input logic dr,
                                input logic z, input logic [14:0] e);
        vec_t v;
        v.start  = s;
        v.op     = op;
        v.iready = ir;
        v.dready = dr;
        v.zero   = z;
        v.exp    = e;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b1; opcode_i = OP_RTYPE; zero_i = 1'b0;
        imem_ready_i = 1'b1; dmem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== NONE) begin
                $display("FAIL reset_outs cyc %0d: got %h required %h", i, outs, NONE);
                errors++;
            end
            checks++;
            if (instr_cnt_o !== 32'd0) begin
                $display("FAIL reset_cnt cyc %0d: got %0d required 0", i, instr_cnt_o);
                errors++;
            end
            next_cycle();
        end
        rst_i = 1'b1;
        $display("test_reset: reset held 3 cycles, released");
    endtask

    task automatic test_rtype();
        vec_t v[$];
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, NONE));
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, F_RDY));
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, RDST | BUSY));
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, RDST | AOP_FN | BUSY));
        v.push_back(mk(0, OP_RTYPE, 1, 1, 0, RDST | RW | BUSY));
        v.push_back(mk(0, OP_RTYPE, 1, 1, 0, NONE));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL rtype step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (instr_cnt_o !== 32'd1) begin
            $display("FAIL rtype_cnt: got %0d required 1", instr_cnt_o);
            errors++;
        end
        $display("test_rtype: cnt=%0d", instr_cnt_o);
    endtask

    task automatic test_addi_lw();
        vec_t v[$];
        v.push_back(mk(1, OP_ADDI, 1, 1, 0, NONE));
        v.push_back(mk(1, OP_ADDI, 1, 1, 0, F_RDY));
        v.push_back(mk(1, OP_ADDI, 1, 1, 0, BUSY));
        v.push_back(mk(1, OP_ADDI, 1, 1, 0, ASRC | BUSY));
        v.push_back(mk(1, OP_ADDI, 1, 1, 0, RW | BUSY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, F_RDY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, BUSY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, ASRC | BUSY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, ASRC | MRD | BUSY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, ASRC | MRD | BUSY));
        v.push_back(mk(1, OP_LW,   1, 0, 0, ASRC | MRD | BUSY));
        v.push_back(mk(1, OP_LW,   1, 1, 0, ASRC | MRD | BUSY));
        v.push_back(mk(0, OP_LW,   1, 1, 0, M2R | RW | BUSY));
        v.push_back(mk(0, OP_LW,   1, 1, 0, NONE));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL addi_lw step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (instr_cnt_o !== 32'd3) begin
            $display("FAIL addi_lw_cnt: got %0d required 3", instr_cnt_o);
            errors++;
        end
        $display("test_addi_lw: cnt=%0d", instr_cnt_o);
    endtask

    task automatic test_beq();
        vec_t v[$];
        v.push_back(mk(1, OP_BEQ, 1, 1, 1, NONE));
        v.push_back(mk(1, OP_BEQ, 1, 1, 1, F_RDY));
        v.push_back(mk(1, OP_BEQ, 1, 1, 1, BUSY));
        v.push_back(mk(1, OP_BEQ, 1, 1, 1, AOP_SB | PCS_BR | PCW | BUSY));
        v.push_back(mk(1, OP_BEQ, 1, 1, 0, F_RDY));
        v.push_back(mk(1, OP_BEQ, 1, 1, 0, BUSY));
        v.push_back(mk(0, OP_BEQ, 1, 1, 0, AOP_SB | PCS_BR | BUSY));
        v.push_back(mk(0, OP_BEQ, 1, 1, 0, NONE));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL beq step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (instr_cnt_o !== 32'd5) begin
            $display("FAIL beq_cnt: got %0d required 5", instr_cnt_o);
            errors++;
        end
        $display("test_beq: cnt=%0d", instr_cnt_o);
    endtask

    task automatic test_jump_illegal();
        vec_t v[$];
        v.push_back(mk(1, OP_J,  1, 1, 0, NONE));
        v.push_back(mk(1, OP_J,  1, 1, 0, F_RDY));
        v.push_back(mk(1, OP_J,  1, 1, 0, PCW | PCS_J | BUSY));
        v.push_back(mk(1, 6'h3F, 1, 1, 0, F_RDY));
        v.push_back(mk(0, 6'h3F, 1, 1, 0, ILL | BUSY));
        v.push_back(mk(0, 6'h3F, 1, 1, 0, NONE));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL jump_illegal step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (instr_cnt_o !== 32'd7) begin
            $display("FAIL jump_illegal_cnt: got %0d required 7", instr_cnt_o);
            errors++;
        end
        $display("test_jump_illegal: cnt=%0d", instr_cnt_o);
    endtask

    task automatic test_stall_reset();
        vec_t v[$];
        v.push_back(mk(1, OP_SW, 0, 0, 0, NONE));
        for (int k = 0; k < 5; k++) v.push_back(mk(1, OP_SW, 0, 0, 0, F_WAIT));
        v.push_back(mk(1, OP_SW, 1, 0, 0, F_RDY));
        v.push_back(mk(1, OP_SW, 1, 0, 0, BUSY));
        v.push_back(mk(1, OP_SW, 1, 0, 0, ASRC | BUSY));
        v.push_back(mk(1, OP_SW, 1, 0, 0, ASRC | MWR | BUSY));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL stall step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        // Still stalled in MEM: write request held, nothing retired yet
        #1;
        checks++;
        if (outs !== (ASRC | MWR | BUSY) || instr_cnt_o !== 32'd7) begin
            $display("FAIL sw_hold: got %h cnt %0d required %h cnt 7",
                     outs, instr_cnt_o, ASRC | MWR | BUSY);
            errors++;
        end
        // Asynchronous reset mid-cycle
        rst_i = 1'b0;
        #1;
        checks++;
        if (outs !== NONE || instr_cnt_o !== 32'd0) begin
            $display("FAIL async_reset: got %h cnt %0d required 0 cnt 0", outs, instr_cnt_o);
            errors++;
        end
        next_cycle();
        start_i = 1'b0; dmem_ready_i = 1'b1; rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_write_o !== 1'b0 || outs !== NONE) begin
                $display("FAIL post_reset cyc %0d: got %h required %h", i, outs, NONE);
                errors++;
            end
            next_cycle();
        end
        $display("test_stall_reset: cnt=%0d", instr_cnt_o);
    endtask

    task automatic test_start_drop();
        vec_t v[$];
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, NONE));
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, F_RDY));
        v.push_back(mk(1, OP_RTYPE, 1, 1, 0, RDST | BUSY));
        v.push_back(mk(0, OP_RTYPE, 1, 1, 0, RDST | AOP_FN | BUSY));
        v.push_back(mk(0, OP_RTYPE, 1, 1, 0, RDST | RW | BUSY));
        v.push_back(mk(0, OP_RTYPE, 1, 1, 0, NONE));
        v.push_back(mk(1, OP_J,     1, 1, 0, NONE));
        v.push_back(mk(1, OP_J,     1, 1, 0, F_RDY));
        v.push_back(mk(0, OP_J,     1, 1, 0, PCW | PCS_J | BUSY));
        v.push_back(mk(0, OP_J,     1, 1, 0, NONE));
        foreach (v[i]) begin
            start_i = v[i].start; opcode_i = v[i].op; imem_ready_i = v[i].iready;
            dmem_ready_i = v[i].dready; zero_i = v[i].zero;
            #1;
            checks++;
            if (outs !== v[i].exp) begin
                $display("FAIL start_drop step %0d: got %h required %h", i, outs, v[i].exp);
                errors++;
            end
            next_cycle();
        end
        checks++;
        if (instr_cnt_o !== 32'd2) begin
            $display("FAIL start_drop_cnt: got %0d required 2", instr_cnt_o);
            errors++;
        end
        $display("test_start_drop: cnt=%0d", instr_cnt_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; opcode_i = '0; zero_i = 1'b0;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        next_cycle();
        test_reset();
        test_rtype();
        test_addi_lw();
        test_beq();
        test_jump_illegal();
        test_stall_reset();
        test_start_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle main controller for the MIPS-subset CPU. It sequences fetch, decode, execute, memory and writeback for R-type, addi, lw, sw, beq and j. It drives every datapath select and enable: the register-destination select (1 = rd for R-type, 0 = rt for addi/lw), ALU source, ALU op, PC source and the write strobes. It also handles ready-handshakes with the instruction and data memories.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-low
start_i  in  1  run enable; sampled at IDLE and at instruction boundaries
opcode_i  in  6  instr[31:26] from IR; valid from DECODE onward
zero_i  in  1  ALU zero flag; valid in EXEC
imem_ready_i  in  1  instruction memory has data this cycle
dmem_ready_i  in  1  data memory access completes this cycle
imem_req_o  out  1  instruction fetch request
ir_write_o  out  1  load IR
pc_write_o  out  1  update PC
pc_src_o  out  2  00 = PC+4, 01 = branch target, 10 = jump target
reg_dst_o  out  1  1 = rd (R-type), 0 = rt
alu_src_o  out  1  1 = sign-extended immediate, 0 = rt data
alu_op_o  out  2  00 = add, 01 = sub, 10 = use funct
mem_read_o  out  1  data read request
mem_write_o  out  1  data write request
mem_to_reg_o  out  1  1 = writeback data comes from memory
reg_write_o  out  1  register file write strobe
illegal_o  out  1  one-cycle pulse on an unknown opcode
busy_o  out  1  high in any state except IDLE
instr_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. State is a register; all outputs are decoded from the state and the latched opcode op_q, except the two Mealy terms noted below.
- Reset (rst_i low, async): state goes to IDLE, op_q to 0, instr_cnt_o to 0. Every output is 0 while reset is asserted and in IDLE. Reset mid-instruction abandons it with no write strobe.
- IDLE: go to FETCH when start_i = 1.
- FETCH:
  - imem_req_o = 1.
  - Stays in FETCH while imem_ready_i = 0.
  - When imem_ready_i = 1 (Mealy): ir_write_o = 1, pc_write_o = 1, pc_src_o = 00; next state DECODE.
- DECODE: op_q <= opcode_i. Transitions:
  - j: pc_write_o = 1, pc_src_o = 10 in this state; retire.
  - unknown opcode: illegal_o = 1; retire; no writes.
  - all others: go to EXEC.
- EXEC:
  - R-type: alu_src_o = 0, alu_op_o = 10; go to WB.
  - addi: alu_src_o = 1, alu_op_o = 00; go to WB.
  - lw/sw: alu_src_o = 1, alu_op_o = 00; go to MEM.
  - beq: alu_src_o = 0, alu_op_o = 01, pc_src_o = 01, pc_write_o = zero_i (Mealy); retire.
- MEM:
  - lw holds mem_read_o = 1 and sw holds mem_write_o = 1 until dmem_ready_i = 1.
  - lw then goes to WB; sw retires.
  - The held ALU-related selects stay stable throughout MEM.
- WB: reg_write_o = 1 for exactly one cycle; retire.
  - R-type: reg_dst_o = 1, mem_to_reg_o = 0.
  - addi: reg_dst_o = 0, mem_to_reg_o = 0.
  - lw: reg_dst_o = 0, mem_to_reg_o = 1.
  - reg_dst_o holds its opcode value from DECODE through WB; it is 0 otherwise.
- Retire:
  - instr_cnt_o increments by 1; it wraps modulo 2^CNT_W. Illegal opcodes also count.
  - Next state is FETCH if start_i = 1, else IDLE. start_i dropping mid-instruction does not abort the instruction.
- Zero-wait latency in cycles: j 2, illegal 2, beq 3, R-type 4, addi 4, sw 4, lw 5. Each wait cycle on a ready input adds 1.
- No two of reg_write_o, mem_write_o and ir_write_o are ever high in the same cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants: OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  - the state enum;
  - the ALU_OP and PC_SRC encodings.
- One natural sub-module: opcode_class, a combinational opcode-to-class decoder (rtype/addi/load/store/branch/jump/illegal). The FSM and counter live in multicycle_ctrl.

Test Plan:
1. Reset held, start_i = 1; release rst_i; R-type opcode, both ready inputs tied to 1 -> IR write at cycle 1, reg_write_o with reg_dst_o = 1 at cycle 4, instr_cnt_o = 1.
2. addi followed by lw with dmem_ready_i low for 3 cycles -> addi WB has reg_dst_o = 0; lw holds mem_read_o for 4 cycles, then WB with mem_to_reg_o = 1; total 8 cycles; count = 2.
3. beq with zero_i = 1, then beq with zero_i = 0 -> first: pc_write_o = 1, pc_src_o = 01 in EXEC; second: pc_write_o = 0; 3 cycles each.
4. j, then opcode 6'h3F -> j: pc_src_o = 10 in DECODE; illegal: illegal_o pulses once and no write strobes; count increments by 2.
5. imem_ready_i low for 5 cycles, then rst_i asserted mid-MEM of an sw -> imem_req_o held for 6 cycles; on reset all outputs 0 immediately, state IDLE, count = 0, no mem_write_o after reset.
6. start_i dropped during EXEC of an R-type -> WB completes, then IDLE with busy_o = 0; start_i = 1 again -> FETCH on the next cycle.
